data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Load/store data memory with RV32I byte/half/word access and fixed response latency.
// Response LATENCY cycles after accept; one request in flight, held in RESP until rsp_ready.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_f3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          f3_ok;
  logic          misalign;
  logic          oob;
  logic          acc_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   merged;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (state == WAIT) && (cnt == 4'd0);

  // Access checks run on the captured request, so req_* may change freely after accept.
  always_comb begin
    f3_ok    = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                    : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    oob      = |addr_q[31:AW+2];
    acc_err  = !f3_ok || misalign || oob;
  end

  assign word_idx = addr_q[AW+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    byte_sel = rd_word[7:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q[1:0])
      2'b00:   load_data = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wlane[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_f3;
      end
      if (commit) begin
        rsp_rdata <= (we_q || acc_err) ? 32'd0 : load_data;
        rsp_err   <= acc_err;
      end
    end
  end

  // Array has no reset; rst_n only blocks a commit that coincides with it.
  always_ff @(posedge clk) begin
    if (rst_n && commit && we_q && !acc_err) begin
      mem[word_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, hold/reset sequences, randomized traffic vs byte-array model.
module tb_data_mem_ctrl;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_f3 = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_f3    (req_f3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [0:4*DEPTH-1];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: legality, little-endian assembly and extension from first principles.
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, output logic [31:0] rdata, output bit err);
    int size;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err   = 0;
    rdata = 32'd0;
    if (f3 == 3'd3 || f3 >= 3'd6) err = 1;
    if (we && f3[2]) err = 1;
    if ((addr % size) != 0) err = 1;
    if (addr >= 4 * DEPTH) err = 1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + i];
        if (size < 4 && !f3[2] && v[8*size-1]) begin
          for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rdata = v;
      end
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the response handshake edge.
  task automatic run_txn(input string name, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_rdata, input bit exp_err, input int ready_delay);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_f3    = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_f3    = 3'($urandom_range(0, 7));
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, LAT);
    check({name, " rdata"}, rsp_rdata, exp_rdata);
    check({name, " err"}, rsp_err, exp_err);
    repeat (ready_delay) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, " rsp_valid drop"}, rsp_valid, 0);
  endtask

  initial begin
    logic [31:0] exp_d;
    bit          exp_e;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    bit          w;
    int          sz;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h11,  32'h00000055, 3'b000, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 1'b0};
    vecs[8]  = '{1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h11,  32'h0000AAAA, 3'b001, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'h10,  32'h00000077, 3'b100, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 1'b0};
    vecs[13] = '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h12,  32'h0000CAFE, 3'b001, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hCAFE55EF, 1'b0};
    vecs[16] = '{1'b0, 32'h10,  32'h0,        3'b001, 32'h000055EF, 1'b0};
    vecs[17] = '{1'b0, 32'h10,  32'h0,        3'b000, 32'hFFFFFFEF, 1'b0};
    vecs[18] = '{1'b0, 32'h12,  32'h0,        3'b101, 32'h0000CAFE, 1'b0};
    vecs[19] = '{1'b0, 32'h3FE, 32'h0,        3'b110, 32'h0,        1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    check("reset req_ready", req_ready, 1);

    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_access(1'b1, 32'(4 * i), d, 3'b010, exp_d, exp_e);
      run_txn("init", 1'b1, 32'(4 * i), d, 3'b010, 32'h0, 1'b0, 0);
    end

    for (int i = 0; i < 20; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, exp_d, exp_e);
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
              vecs[i].rdata, vecs[i].err, i % 3);
    end

    // Backpressure: response must hold while a competing request is presented.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_f3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    check("hold first rsp_valid", rsp_valid, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_f3 = 3'b010;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d rsp_valid", c), rsp_valid, 1);
      check($sformatf("hold%0d rsp_rdata", c), rsp_rdata, 32'hCAFE55EF);
      check($sformatf("hold%0d req_ready", c), req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("hold release rsp_valid", rsp_valid, 0);
    check("hold release req_ready", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold after%0d rsp_valid", c), rsp_valid, 0);
    end
    model_access(1'b0, 32'h10, 32'h0, 3'b010, exp_d, exp_e);
    run_txn("hold readback", 1'b0, 32'h10, 32'h0, 3'b010, exp_d, exp_e, 0);

    // Reset lands on the edge that would have committed the store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_f3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst mid rsp_valid", rsp_valid, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    check("rst rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    check("rst release req_ready", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst idle%0d rsp_valid", c), rsp_valid, 0);
    end
    model_access(1'b0, 32'h20, 32'h0, 3'b010, exp_d, exp_e);
    run_txn("rst readback", 1'b0, 32'h20, 32'h0, 3'b010, exp_d, exp_e, 1);

    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
          : (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      d = $urandom;
      model_access(w, a, d, f, exp_d, exp_e);
      run_txn("rand", w, a, d, f, exp_d, exp_e, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
